// File: rtl/divider_8_seq.sv
// rtl/divider_8_seq.sv - sequential unsigned restoring divider, one quotient bit per clock (optional DIV_DBZ_EN divide-by-zero shortcut)
module divider_8_seq #(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [M-1:0] B,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] q,
    output logic [M-1:0] r,
    output logic         out_valid,
`ifdef DIV_DBZ_EN
    output logic         dbz,
`endif
    input  logic         out_ready
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quo_q, quo_d;
    // The partial remainder settled after each iteration always fits in M
    // bits; the extra sign bit only exists in the combinational trial below.
    logic [M-1:0]  rem_q, rem_d;
    logic [M-1:0]  div_q, div_d;
`ifdef DIV_DBZ_EN
    logic          dbz_q, dbz_d;
`endif

    logic [M:0]    shifted;
    logic [M:0]    trial;

    // Next-state, datapath iteration and handshake decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div_d   = div_q;
`ifdef DIV_DBZ_EN
        dbz_d   = dbz_q;
`endif
        // Shift {rem,quo} left by one and try subtracting the divisor.
        shifted = {rem_q, quo_q[N-1]};
        trial   = shifted - {1'b0, div_q};

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    div_d   = B;
                    quo_d   = A;
                    rem_d   = '0;
                    cnt_d   = CW'(N - 1);
                    state_d = S_CALC;
`ifdef DIV_DBZ_EN
                    // Zero divisor skips the iterations and reports directly.
                    if (B == '0) begin
                        quo_d   = '1;
                        rem_d   = M'(A);
                        cnt_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                // A clear sign bit means the subtraction fits: keep it and
                // record a 1; otherwise restore the shifted remainder.
                if (!trial[M]) begin
                    rem_d = trial[M-1:0];
                end else begin
                    rem_d = shifted[M-1:0];
                end
                quo_d = {quo_q[N-2:0], ~trial[M]};
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
`ifdef DIV_DBZ_EN
                    dbz_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
`ifdef DIV_DBZ_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
`ifdef DIV_DBZ_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign q         = quo_q;
    assign r         = rem_q;
`ifdef DIV_DBZ_EN
    assign dbz       = dbz_q;
`endif

endmodule

// File: tb/tb_divider_8_seq.sv
// tb/tb_divider_8_seq.sv - scoreboard bench for divider_8_seq with directed and random operations
module tb_divider_8_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] A = 8'd0;
    logic [7:0] B = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] q;
    logic [7:0] r;
    logic       out_valid;
    logic       out_ready = 1'b0;
`ifdef DIV_DBZ_EN
    logic       dbz;
    localparam int DBZ_LAT = 0;
`else
    localparam int DBZ_LAT = 8;
`endif

    divider_8_seq #(.N(8), .M(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .r         (r),
        .out_valid (out_valid),
`ifdef DIV_DBZ_EN
        .dbz       (dbz),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        bit         dbz;
        bit         rt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    bit ready_rand  = 1'b0;
    bit ready_fixed = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Arithmetic reference: quotient/remainder by plain division, zero divisor saturates.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input bit rt);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.rt = rt;
        if (b == 8'd0) begin
            e.q   = 8'hFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Consumer ready, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // Monitor: every output handshake pops and checks one expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: got result q=%0d r=%0d with nothing expected", q, r);
            end else begin
                mon_e = sb.pop_front();
                check("q", 32'(q), 32'(mon_e.q));
                check("r", 32'(r), 32'(mon_e.r));
`ifdef DIV_DBZ_EN
                check("dbz", 32'(dbz), 32'(mon_e.dbz));
`endif
                if (mon_e.rt) begin
                    tests++;
                    if ((32'(q) * 32'(mon_e.b) + 32'(r) != 32'(mon_e.a)) || (r >= mon_e.b)) begin
                        fails++;
                        $display("FAIL roundtrip *ERROR*: A=%0d B=%0d got q=%0d r=%0d", mon_e.a, mon_e.b, q, r);
                    end
                end
            end
        end
    end

    // Present one operation and complete its input handshake; returns at edge0 + 1.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit push, input bit rt);
        int n;
        @(negedge clk);
        A = a;
        B = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: in_ready got 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        if (push) sb.push_back(model(a, b, rt));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = ~a;
        B = ~b;
    endtask

    // Count rising edges after the handshake edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL valid_timeout: out_valid got 0 expected 1");
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: in_ready got 0 expected 1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         n;
        logic [7:0] hq;
        logic [7:0] hr;
        logic [7:0] ra;
        logic [7:0] rb;

        // Reset state, while held and after release.
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_r", 32'(r), 32'd0);
`ifdef DIV_DBZ_EN
        check("rst_dbz", 32'(dbz), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Basic division and its latency.
        issue(8'd200, 8'd7, 1'b1, 1'b0);
        wait_valid(lat);
        check("t1_latency", 32'(lat), 32'd8);
        wait_idle();

        // B=1, A<B, A=0.
        issue(8'd255, 8'd1, 1'b1, 1'b0);
        wait_valid(lat);
        wait_idle();
        issue(8'd5, 8'd9, 1'b1, 1'b0);
        wait_valid(lat);
        wait_idle();
        issue(8'd0, 8'd37, 1'b1, 1'b0);
        wait_valid(lat);
        wait_idle();

        // Zero divisor.
        issue(8'd100, 8'd0, 1'b1, 1'b0);
        wait_valid(lat);
        check("t3_latency", 32'(lat), 32'(DBZ_LAT));
        wait_idle();
`ifdef DIV_DBZ_EN
        check("t3_dbz_clear", 32'(dbz), 32'd0);
`endif

        // Backpressure in DONE.
        ready_fixed = 1'b0;
        issue(8'd123, 8'd10, 1'b1, 1'b0);
        wait_valid(lat);
        hq = q;
        hr = r;
        check("bp_q_value", 32'(hq), 32'd12);
        check("bp_r_value", 32'(hr), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_q_stable", 32'(q), 32'(hq));
            check("bp_r_stable", 32'(r), 32'(hr));
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        ready_fixed = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Reset during the third CALC iteration aborts the operation.
        issue(8'd77, 8'd3, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_q", 32'(q), 32'd0);
        check("abort_r", 32'(r), 32'd0);
        rst = 1'b0;
        issue(8'd77, 8'd3, 1'b1, 1'b0);
        wait_valid(lat);
        check("t5_latency", 32'(lat), 32'd8);
        wait_idle();

        // Random operands with random consumer backpressure.
        ready_rand = 1'b1;
        for (int i = 0; i < 15; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            issue(ra, rb, 1'b1, 1'b1);
        end
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
        ready_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
